// File: rtl/filtro_rebote_multicanal.sv
// Multi-channel input filter: per-channel 2-flop synchroniser followed by either
// a non-retriggerable one-shot (MODO 0) or a stable-level debouncer (MODO 1).
module filtro_rebote_multicanal #(
  parameter int unsigned CANALES     = 4,
  parameter int unsigned CLK_KHZ     = 50000,
  parameter int unsigned DURACION_MS = 20,
  parameter int unsigned MODO        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CANALES-1:0] pulso_real,
  output logic [CANALES-1:0] pulso_ideal,
  output logic [CANALES-1:0] flanco_subida,
  output logic [CANALES-1:0] flanco_bajada
);

  localparam int unsigned CICLOS = CLK_KHZ * DURACION_MS;
  localparam int unsigned CW     = $clog2(CICLOS + 1);
  localparam logic [CW-1:0] FIN  = CW'(CICLOS - 1);

  if (CICLOS < 2 || MODO > 1 || CANALES < 1) begin : g_param_invalido
    $error("filtro_rebote_multicanal: needs CICLOS >= 2, MODO in {0,1}, CANALES >= 1");
  end

  for (genvar g = 0; g < CANALES; g++) begin : g_canal
    logic          r_s1;
    logic          r_s2;
    logic          r_ideal;
    logic          r_sub;
    logic          r_baj;
    logic [CW-1:0] r_cnt;

    assign pulso_ideal[g]   = r_ideal;
    assign flanco_subida[g] = r_sub;
    assign flanco_bajada[g] = r_baj;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= pulso_real[g];
        r_s2 <= r_s1;
      end
    end

    if (MODO == 0) begin : g_one_shot
      typedef enum logic [1:0] {REPOSO, ACTIVO, ESPERA} estado_t;
      estado_t r_estado;

      // Strobes are set alongside the level change so they track its next value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_estado <= REPOSO;
          r_ideal  <= 1'b0;
          r_sub    <= 1'b0;
          r_baj    <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_sub <= 1'b0;
          r_baj <= 1'b0;
          case (r_estado)
            REPOSO: begin
              r_cnt <= '0;
              if (r_s2) begin
                r_estado <= ACTIVO;
                r_ideal  <= 1'b1;
                r_sub    <= 1'b1;
              end
            end
            ACTIVO: begin
              if (r_cnt == FIN) begin
                r_ideal  <= 1'b0;
                r_baj    <= 1'b1;
                r_cnt    <= '0;
                r_estado <= r_s2 ? ESPERA : REPOSO;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            ESPERA: begin
              if (!r_s2) r_estado <= REPOSO;
            end
            default: r_estado <= REPOSO;
          endcase
        end
      end
    end else begin : g_debounce
      // Any sample equal to the output restarts the stability count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ideal <= 1'b0;
          r_sub   <= 1'b0;
          r_baj   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sub <= 1'b0;
          r_baj <= 1'b0;
          if (r_s2 == r_ideal) begin
            r_cnt <= '0;
          end else if (r_cnt == FIN) begin
            r_ideal <= r_s2;
            r_sub   <= r_s2;
            r_baj   <= ~r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_filtro_rebote_multicanal.sv
// Scoreboard bench: one MODO 0 and one MODO 1 instance share stimulus; a timing
// model predicts each cycle's outputs and a monitor compares them.
module tb_filtro_rebote_multicanal;

  localparam int CIC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b00;
  logic [1:0] i0, s0, b0, i1, s1, b1;

  always #5 clk = ~clk;

  filtro_rebote_multicanal #(.CANALES(2), .CLK_KHZ(1), .DURACION_MS(4), .MODO(0)) dut0 (
    .clk(clk), .rst(rst), .pulso_real(din),
    .pulso_ideal(i0), .flanco_subida(s0), .flanco_bajada(b0)
  );

  filtro_rebote_multicanal #(.CANALES(2), .CLK_KHZ(1), .DURACION_MS(4), .MODO(1)) dut1 (
    .clk(clk), .rst(rst), .pulso_real(din),
    .pulso_ideal(i1), .flanco_subida(s1), .flanco_bajada(b1)
  );

  typedef struct packed {
    logic [1:0] i0, s0, b0, i1, s1, b1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, got, req, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, req, $time);
    end
  endtask

  // Reference model state: input delay line, one-shot timeline, debounce window
  logic [1:0]     p1, p2, out0, out1;
  bit             busy [2];
  bit             armed [2];
  int             start [2];
  int             edge_n;
  logic [CIC-1:0] win [2];

  task automatic model_reset();
    p1 = '0; p2 = '0; out0 = '0; out1 = '0; edge_n = 0;
    for (int c = 0; c < 2; c++) begin
      busy[c] = 1'b0; armed[c] = 1'b1; start[c] = 0; win[c] = '0;
    end
  endtask

  initial begin
    logic [1:0] v, n0, n1;
    exp_t       e;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
        q.delete();
        q.push_back('0);
      end else begin
        v  = p2;
        p2 = p1;
        p1 = din;
        edge_n++;
        n0 = out0;
        n1 = out1;
        for (int c = 0; c < 2; c++) begin
          // One-shot: CIC-cycle pulse; a low sample is needed to re-arm
          if (busy[c]) begin
            if (edge_n == start[c] + CIC) begin
              busy[c]  = 1'b0;
              armed[c] = !v[c];
            end
          end else if (!v[c]) begin
            armed[c] = 1'b1;
          end else if (armed[c]) begin
            busy[c]  = 1'b1;
            armed[c] = 1'b0;
            start[c] = edge_n;
          end
          n0[c] = busy[c];
          // Debounce: flip once the last CIC samples all differ from the output
          win[c] = {win[c][CIC-2:0], v[c]};
          if (out1[c] ? (win[c] == '0) : (win[c] == '1)) n1[c] = v[c];
        end
        e.i0 = n0; e.s0 = n0 & ~out0; e.b0 = ~n0 & out0;
        e.i1 = n1; e.s1 = n1 & ~out1; e.b1 = ~n1 & out1;
        out0 = n0;
        out1 = n1;
        q.push_back(e);
      end
    end
  end

  // Monitor: one expected entry per cycle, plus strobe and pulse-length rules
  initial begin
    exp_t       e;
    int         len [2];
    logic [1:0] prev;
    len[0] = 0; len[1] = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        check("sb dut0 pulso_ideal", i0, e.i0);
        check("sb dut0 flanco_subida", s0, e.s0);
        check("sb dut0 flanco_bajada", b0, e.b0);
        check("sb dut1 pulso_ideal", i1, e.i1);
        check("sb dut1 flanco_subida", s1, e.s1);
        check("sb dut1 flanco_bajada", b1, e.b1);
      end
      check("dut0 strobes overlap", s0 & b0, 2'b00);
      check("dut1 strobes overlap", s1 & b1, 2'b00);
      if (rst) begin
        len[0] = 0; len[1] = 0; prev = '0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (i0[c]) begin
            len[c]++;
          end else begin
            if (prev[c]) check_cnt("dut0 pulse length", len[c], CIC);
            len[c] = 0;
          end
        end
        prev = i0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] ei, es, eb;
    int         nsub, nhigh;
    int         rem [2];

    step(3);
    #2 rst = 1'b0;

    // 1: two-cycle press on ch0 gives one 4-cycle pulse from edge k+2
    step(10);
    din = 2'b01;
    ei = 8'b0011_1100; es = 8'b0000_0100; eb = 8'b0100_0000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 1) din = 2'b00;
      check("t1 pulso_ideal", i0, {1'b0, ei[i]});
      check("t1 flanco_subida", s0, {1'b0, es[i]});
      check("t1 flanco_bajada", b0, {1'b0, eb[i]});
    end

    // 2: held input fires once; re-arm only after a low sample
    step(4);
    din = 2'b01; nsub = 0;
    for (int i = 0; i < 20; i++) begin step(1); nsub += int'(s0[0]); end
    check_cnt("t2 pulses while held", nsub, 1);
    din = 2'b00;
    step(2);
    din = 2'b01; nsub = 0;
    for (int i = 0; i < 8; i++) begin step(1); nsub += int'(s0[0]); end
    check_cnt("t2 pulses after re-press", nsub, 1);

    // 3: 3-cycle glitches never reach the debounced output; steady hold does
    din = 2'b00;
    step(12);
    nhigh = 0;
    for (int r = 0; r < 3; r++) begin
      din = 2'b01;
      for (int i = 0; i < 3; i++) begin step(1); nhigh += int'(i1[0]); end
      din = 2'b00;
      for (int i = 0; i < 3; i++) begin step(1); nhigh += int'(i1[0]); end
    end
    check_cnt("t3 glitch high cycles", nhigh, 0);
    din = 2'b01;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("t3 debounce rise", i1, {1'b0, i >= 5});
    end
    din = 2'b00;
    step(12);

    // 4: both channels pressed together, released at different times
    din = 2'b11;
    for (int i = 0; i < 18; i++) begin
      step(1);
      if (i == 5) din[0] = 1'b0;
      if (i == 9) din[1] = 1'b0;
      check("t4 levels", i1, {i >= 5 && i <= 14, i >= 5 && i <= 10});
      check("t4 flanco_subida", s1, (i == 5) ? 2'b11 : 2'b00);
      check("t4 flanco_bajada", b1, {i == 15, i == 11});
    end
    step(6);

    // 5: reset mid-pulse clears everything at once; held input re-fires after release
    din = 2'b01;
    step(4);
    #2 rst = 1'b1;
    #1;
    check("t5 reset dut0 pulso_ideal", i0, 2'b00);
    check("t5 reset dut0 flanco_subida", s0, 2'b00);
    check("t5 reset dut0 flanco_bajada", b0, 2'b00);
    check("t5 reset dut1 pulso_ideal", i1, 2'b00);
    check("t5 reset dut1 flanco_subida", s1, 2'b00);
    check("t5 reset dut1 flanco_bajada", b1, 2'b00);
    step(3);
    #2 rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check("t5 one-shot after reset", i0, {1'b0, i >= 3 && i <= 6});
      check("t5 debounce after reset", i1, {1'b0, i >= 6});
    end
    din = 2'b00;
    step(12);

    // 6: random bounce on both channels
    rem[0] = 1; rem[1] = 1;
    for (int t = 0; t < 2000; t++) begin
      for (int c = 0; c < 2; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          din[c] = ~din[c];
          rem[c] = int'($urandom_range(1, 12));
        end
      end
      step(1);
    end
    din = 2'b00;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
